// File: rtl/ser_frame_pkg.sv
// Shared types and default parameters for the serial frame detector.
package ser_frame_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LEN     = 2'd1,
        PAYLOAD = 2'd2
    } state_e;

    localparam int unsigned            DEF_PAT_W   = 4;
    localparam logic [DEF_PAT_W-1:0]   DEF_PATTERN = 4'b1011;
    localparam int unsigned            DEF_LEN_W   = 3;
    localparam int unsigned            DEF_CNT_W   = 8;

endpackage

// File: rtl/ser_bit_counter.sv
// Loadable saturating down counter with clock enable and a zero flag.
// A reload value of N means "N more enabled decrements until zero".
module ser_bit_counter #(
    parameter int unsigned  W       = 3,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_en,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins over decrement; decrement stops at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register, frozen while clk_en is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= RST_VAL;
        end else if (clk_en) begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ser_frame_detector.sv
// Serial frame detector: hunts for a sync pattern, reads a length field,
// then forwards that many payload bits with a valid strobe.
module ser_frame_detector
    import ser_frame_pkg::*;
#(
    parameter int unsigned      PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
    parameter int unsigned      LEN_W   = DEF_LEN_W,
    parameter int unsigned      CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             ser_out_valid,
    output logic             frame_done,
    output logic             len_err,
    output logic             busy,
    output logic [CNT_W-1:0] frame_count
);

    // Fill counter holds "bits still missing before a match may fire, minus one"
    localparam int unsigned FILL_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam int unsigned BIT_W  = LEN_W;

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ser_out_q, ser_out_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   fcnt_q, fcnt_d;

    logic               fill_load, fill_dec, fill_zero;
    logic               bit_load, bit_dec, bit_zero;
    logic [BIT_W-1:0]   bit_val;

    // HUNT fill tracker; reloads to "empty" whenever the FSM is outside HUNT
    ser_bit_counter #(
        .W       (FILL_W),
        .RST_VAL (FILL_W'(PAT_W - 1))
    ) u_fill_cnt (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .load_i     (fill_load),
        .load_val_i (FILL_W'(PAT_W - 1)),
        .dec_i      (fill_dec),
        .zero_o     (fill_zero)
    );

    // Remaining length-field / payload bits, minus one
    ser_bit_counter #(
        .W       (BIT_W),
        .RST_VAL ('0)
    ) u_bit_cnt (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .load_i     (bit_load),
        .load_val_i (bit_val),
        .dec_i      (bit_dec),
        .zero_o     (bit_zero)
    );

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        pat_d     = '0;
        len_d     = len_q;
        ser_out_d = ser_out_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        fcnt_d    = fcnt_q;
        fill_load = 1'b1;
        fill_dec  = 1'b0;
        bit_load  = 1'b0;
        bit_dec   = 1'b0;
        bit_val   = '0;

        case (state_q)
            HUNT: begin
                pat_d     = PAT_W'({pat_q, ser_in});
                fill_load = 1'b0;
                fill_dec  = 1'b1;
                if (fill_zero && (pat_d == PATTERN)) begin
                    state_d   = LEN;
                    pat_d     = '0;
                    len_d     = '0;
                    fill_load = 1'b1;
                    bit_load  = 1'b1;
                    bit_val   = BIT_W'(LEN_W - 1);
                end
            end
            LEN: begin
                len_d   = LEN_W'({len_q, ser_in});
                bit_dec = 1'b1;
                if (bit_zero) begin
                    if (len_d == '0) begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                    end else begin
                        state_d  = PAYLOAD;
                        bit_load = 1'b1;
                        bit_val  = BIT_W'(len_d - LEN_W'(1));
                    end
                end
            end
            PAYLOAD: begin
                ser_out_d = ser_in;
                valid_d   = 1'b1;
                bit_dec   = 1'b1;
                if (bit_zero) begin
                    done_d  = 1'b1;
                    fcnt_d  = fcnt_q + CNT_W'(1);
                    state_d = HUNT;
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase

        busy_d = (state_d != HUNT);
    end

    // State and output registers, frozen while clk_en is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= HUNT;
            pat_q     <= '0;
            len_q     <= '0;
            ser_out_q <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            fcnt_q    <= '0;
        end else if (clk_en) begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            ser_out_q <= ser_out_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            fcnt_q    <= fcnt_d;
        end
    end

    assign ser_out       = ser_out_q;
    assign ser_out_valid = valid_q;
    assign frame_done    = done_q;
    assign len_err       = err_q;
    assign busy          = busy_q;
    assign frame_count   = fcnt_q;

endmodule

// File: tb/tb_ser_frame_detector.sv
// Directed bench for ser_frame_detector (default widths plus a CNT_W=2 copy).
module tb_ser_frame_detector;

    logic       clk;
    logic       rst;
    logic       clk_en;
    logic       ser_in;

    logic       so1, sv1, fd1, le1, bz1;
    logic [7:0] fc1;
    logic       so2, sv2, fd2, le2, bz2;
    logic [1:0] fc2;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit       ser_in;
        bit       en;
        bit       valid;
        bit       out;
        bit       done;
        bit       err;
        bit       busy;
        bit [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    ser_frame_detector dut1 (
        .clk           (clk),
        .rst           (rst),
        .clk_en        (clk_en),
        .ser_in        (ser_in),
        .ser_out       (so1),
        .ser_out_valid (sv1),
        .frame_done    (fd1),
        .len_err       (le1),
        .busy          (bz1),
        .frame_count   (fc1)
    );

    ser_frame_detector #(.CNT_W(2)) dut2 (
        .clk           (clk),
        .rst           (rst),
        .clk_en        (clk_en),
        .ser_in        (ser_in),
        .ser_out       (so2),
        .ser_out_valid (sv2),
        .frame_done    (fd2),
        .len_err       (le2),
        .busy          (bz2),
        .frame_count   (fc2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [12:0] obs1();
        return {sv1, so1, fd1, le1, bz1, fc1};
    endfunction

    function automatic logic [6:0] obs2();
        return {sv2, so2, fd2, le2, bz2, fc2};
    endfunction

    function automatic vec_t mk(bit i, bit v, bit o, bit d, bit e, bit b, bit [7:0] c);
        vec_t r;
        r.ser_in = i; r.en = 1'b1; r.valid = v; r.out = o;
        r.done = d; r.err = e; r.busy = b; r.cnt = c;
        return r;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        ser_in = v.ser_in;
        clk_en = v.en;
        @(posedge clk);
        #1;
        check(name, 16'(obs1()), 16'({v.valid, v.out, v.done, v.err, v.busy, v.cnt}));
    endtask

    task automatic drive(input bit b);
        ser_in = b;
        clk_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("%s vec %0d", tag, i));
        end
        vecs.delete();
    endtask

    task automatic do_reset(input string name);
        #2 rst = 1'b0;
        clk_en = 1'b0;
        #1;
        check({name, " dut1"}, 16'(obs1()), 16'(0));
        check({name, " dut2"}, 16'(obs2()), 16'(0));
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    initial begin
        int         vcount;
        vec_t       r;
        bit         fr [8];
        logic [1:0] exp2 [5];

        rst    = 1'b0;
        clk_en = 1'b0;
        ser_in = 1'b0;
        #1;
        do_reset("reset0");

        // Frame 1011 / len 011 / payload 010, then trailing 1101 that must not match
        vecs.push_back(mk(1,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,1,0));
        vecs.push_back(mk(0,1,0,0,0,1,0));
        vecs.push_back(mk(1,1,1,0,0,1,0));
        vecs.push_back(mk(0,1,0,1,0,0,1));
        vecs.push_back(mk(1,0,0,0,0,0,1));
        vecs.push_back(mk(1,0,0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,0,0,1));
        vecs.push_back(mk(1,0,0,0,0,0,1));
        run_table("basic");

        // Zero length field, then a one-bit frame
        do_reset("reset1");
        vecs.push_back(mk(1,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,1,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,1,0));
        vecs.push_back(mk(1,1,1,1,0,0,1));
        run_table("lenerr");

        // Overlapping sync, payload 1011 + 011 not a frame, fresh sync then len 0
        do_reset("reset2");
        vecs.push_back(mk(1,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,1,0));
        vecs.push_back(mk(1,1,1,1,0,0,1));
        vecs.push_back(mk(1,0,1,0,0,0,1));
        vecs.push_back(mk(0,0,1,0,0,0,1));
        vecs.push_back(mk(1,0,1,0,0,0,1));
        vecs.push_back(mk(1,0,1,0,0,1,1));
        vecs.push_back(mk(1,0,1,0,0,1,1));
        vecs.push_back(mk(0,0,1,0,0,1,1));
        vecs.push_back(mk(0,0,1,0,0,1,1));
        vecs.push_back(mk(1,1,1,0,0,1,1));
        vecs.push_back(mk(0,1,0,0,0,1,1));
        vecs.push_back(mk(1,1,1,0,0,1,1));
        vecs.push_back(mk(1,1,1,1,0,0,2));
        vecs.push_back(mk(0,0,1,0,0,0,2));
        vecs.push_back(mk(1,0,1,0,0,0,2));
        vecs.push_back(mk(1,0,1,0,0,0,2));
        vecs.push_back(mk(1,0,1,0,0,0,2));
        vecs.push_back(mk(0,0,1,0,0,0,2));
        vecs.push_back(mk(1,0,1,0,0,0,2));
        vecs.push_back(mk(1,0,1,0,0,1,2));
        vecs.push_back(mk(0,0,1,0,0,1,2));
        vecs.push_back(mk(0,0,1,0,0,1,2));
        vecs.push_back(mk(0,0,1,0,1,0,2));
        run_table("overlap");

        // Length-7 frame with clk_en toggling every cycle; disabled edges see inverted data
        do_reset("reset3");
        vecs.push_back(mk(1,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,1,0));
        vecs.push_back(mk(1,1,1,0,0,1,0));
        vecs.push_back(mk(0,1,0,0,0,1,0));
        vecs.push_back(mk(0,1,0,0,0,1,0));
        vecs.push_back(mk(1,1,1,0,0,1,0));
        vecs.push_back(mk(1,1,1,0,0,1,0));
        vecs.push_back(mk(0,1,0,0,0,1,0));
        vecs.push_back(mk(1,1,1,1,0,0,1));
        vcount = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("clken on %0d", i));
            if (sv1) vcount++;
            r        = vecs[i];
            r.ser_in = ~vecs[i].ser_in;
            r.en     = 1'b0;
            apply(r, $sformatf("clken off %0d", i));
        end
        vecs.delete();
        check("clken valid count", 16'(vcount), 16'(7));

        // Asynchronous reset in the middle of a payload aborts the frame
        do_reset("reset4");
        fr = '{1,0,1,1,0,1,1,1};
        for (int i = 0; i < 8; i++) drive(fr[i]);
        check("pre-abort", 16'(obs1()), 16'({1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0}));
        #2 rst = 1'b0;
        #1;
        check("async clear dut1", 16'(obs1()), 16'(0));
        check("async clear dut2", 16'(obs2()), 16'(0));
        @(posedge clk);
        #2 rst = 1'b1;
        fr = '{1,0,1,1,0,0,1,1};
        for (int i = 0; i < 8; i++) drive(fr[i]);
        check("post-abort frame", 16'(obs1()), 16'({1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1}));

        // Frame counter wrap on the CNT_W=2 copy
        do_reset("reset5");
        exp2 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int f = 0; f < 5; f++) begin
            fr    = '{1,0,1,1,0,0,1,0};
            fr[7] = f[0];
            for (int i = 0; i < 8; i++) drive(fr[i]);
            check($sformatf("wrap cnt8 %0d", f), 16'({fd1, fc1}), 16'({1'b1, 8'(f + 1)}));
            check($sformatf("wrap cnt2 %0d", f), 16'({fd2, so2, fc2}), 16'({1'b1, f[0], exp2[f]}));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
